// File: rtl/temporal_encoder_if.sv
// Handshake and output bundle for temporal_encoder.
// The encoder sits on the slave side. The producer of value vectors, which also
// observes the temporal-coded lines, sits on the master side.
interface temporal_encoder_if #(
  parameter int N = 4,
  parameter int W = 3
);
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   lines_out;
  logic           wave_start;
  logic           wave_done;
  logic           busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, lines_out, wave_start, wave_done, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, lines_out, wave_start, wave_done, busy
  );
endinterface

// File: rtl/temporal_encoder.sv
// temporal_encoder: turns N binary W-bit time values into a temporal-coded wave.
// Line i idles high and falls at cycle offset v_i within a RUN window of T cycles.
// After the window, all lines stay high for GAP recovery cycles, and then the
// encoder accepts the next vector.
// Optional feature macro TENC_NULL_EN: the all-ones code means "no spike" and
// the window shrinks to T = 2^W-1. Without the macro, T = 2^W and every code is
// a valid time.
module temporal_encoder #(
  parameter int N   = 4,
  parameter int W   = 3,
  parameter int GAP = 1
) (
  input  logic               clk,
  input  logic               rst,
  temporal_encoder_if.slave  bus
);

`ifdef TENC_NULL_EN
  localparam int T = (1 << W) - 1;
`else
  localparam int T = (1 << W);
`endif
  localparam logic [W-1:0] T_LAST   = W'(T - 1);
  localparam int           GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    t_reg;
  logic [GW-1:0]   gap_reg;
  logic [W-1:0]    val_reg [N];
  logic [N-1:0]    lines_reg;
  logic            in_ready_reg;
  logic            wave_start_reg;
  logic            wave_done_reg;
  logic            busy_reg;

  logic [W-1:0]    t_next;
  logic [W-1:0]    in_val [N];
  logic [N-1:0]    fall_first;
  logic [N-1:0]    fall_next;

  // Line i is low at time t once its value has been reached. Under the null
  // option, the all-ones code never spikes.
  function automatic logic spiked_by(input logic [W-1:0] v, input logic [W-1:0] t);
`ifdef TENC_NULL_EN
    return (v <= t) && (v != {W{1'b1}});
`else
    return (v <= t);
`endif
  endfunction

  assign t_next = t_reg + 1'b1;

  // Per-line compares. The first RUN cycle is computed from the incoming data,
  // so the accept edge already loads the t = 0 pattern into the output register.
  // Later cycles compare the latched value against the upcoming time.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_line
      assign in_val[gi]     = bus.in_data[gi*W +: W];
      assign fall_first[gi] = spiked_by(in_val[gi], '0);
      assign fall_next[gi]  = spiked_by(val_reg[gi], t_next);
    end
  endgenerate

  assign bus.lines_out  = lines_reg;
  assign bus.in_ready   = in_ready_reg;
  assign bus.wave_start = wave_start_reg;
  assign bus.wave_done  = wave_done_reg;
  assign bus.busy       = busy_reg;

  // Encoder FSM: handshake in IDLE, timed wave in RUN, all-high gap in RECOVER.
  // Every output is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      t_reg          <= '0;
      gap_reg        <= '0;
      for (int i = 0; i < N; i++) val_reg[i] <= '0;
      lines_reg      <= '1;
      in_ready_reg   <= 1'b0;
      wave_start_reg <= 1'b0;
      wave_done_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      wave_start_reg <= 1'b0;
      wave_done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          lines_reg <= '1;
          busy_reg  <= 1'b0;
          if (bus.in_valid && in_ready_reg) begin
            for (int i = 0; i < N; i++) val_reg[i] <= in_val[i];
            state_reg      <= RUN;
            t_reg          <= '0;
            in_ready_reg   <= 1'b0;
            busy_reg       <= 1'b1;
            wave_start_reg <= 1'b1;
            // A single-cycle window both starts and ends on t = 0.
            wave_done_reg  <= (T_LAST == '0);
            lines_reg      <= ~fall_first;
          end else begin
            in_ready_reg <= 1'b1;
          end
        end

        RUN: begin
          if (t_reg == T_LAST) begin
            lines_reg <= '1;
            t_reg     <= '0;
            if (GAP > 0) begin
              state_reg <= RECOVER;
              gap_reg   <= '0;
            end else begin
              state_reg    <= IDLE;
              in_ready_reg <= 1'b1;
              busy_reg     <= 1'b0;
            end
          end else begin
            t_reg         <= t_next;
            lines_reg     <= ~fall_next;
            wave_done_reg <= (t_next == T_LAST);
          end
        end

        RECOVER: begin
          lines_reg <= '1;
          if (gap_reg == GAP_LAST) begin
            state_reg    <= IDLE;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
            gap_reg      <= '0;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end

        default: begin
          state_reg    <= IDLE;
          lines_reg    <= '1;
          in_ready_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench for temporal_encoder. An expected-cycle scoreboard is filled on
// each accept from an independent model of the line timing, and it is drained
// and compared cycle by cycle while the wave plays out.
module tb_temporal_encoder;
  localparam int N   = 4;
  localparam int W   = 3;
  localparam int GAP = 1;
`ifdef TENC_NULL_EN
  localparam bit NULL_EN = 1'b1;
  localparam int T       = (1 << W) - 1;
`else
  localparam bit NULL_EN = 1'b0;
  localparam int T       = (1 << W);
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  temporal_encoder_if #(.N(N), .W(W)) bus ();

  temporal_encoder #(.N(N), .W(W), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [N-1:0] lines;
    logic         start;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference timing: a line is low at time t once its value is <= t. Under the
  // null option, the all-ones code never falls.
  function automatic logic [N-1:0] model_lines(input logic [N*W-1:0] vec, input int t);
    logic [N-1:0] r;
    int v;
    for (int i = 0; i < N; i++) begin
      v = int'(vec[i*W +: W]);
      r[i] = !((v <= t) && !(NULL_EN && v == (1 << W) - 1));
    end
    return r;
  endfunction

  function automatic void push_wave(input logic [N*W-1:0] vec);
    exp_t e;
    for (int t = 0; t < T; t++) begin
      e.lines = model_lines(vec, t);
      e.start = (t == 0);
      e.done  = (t == T - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one vector. The call starts in an IDLE cycle with in_ready high.
  task automatic accept(input logic [N*W-1:0] vec);
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = vec;
    push_wave(vec);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = (N*W)'($urandom);
    $display("accept vector %h", vec);
  endtask

  // Compare n RUN cycles against the scoreboard.
  task automatic run_cycles(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("lines_c%0d", c), 32'(bus.lines_out), 32'(e.lines));
        check($sformatf("start_c%0d", c), 32'(bus.wave_start), 32'(e.start));
        check($sformatf("done_c%0d", c), 32'(bus.wave_done), 32'(e.done));
        check($sformatf("busy_c%0d", c), 32'(bus.busy), 32'd1);
        check($sformatf("ready_c%0d", c), 32'(bus.in_ready), 32'd0);
      end
      tick();
    end
  endtask

  // The first cycle after the window, the recovery gap, and the return to IDLE.
  task automatic finish_wave();
    check("post_lines", 32'(bus.lines_out), 32'hF);
    check("post_busy", 32'(bus.busy), 32'(GAP > 0));
    check("post_ready", 32'(bus.in_ready), 32'(GAP == 0));
    check("post_done", 32'(bus.wave_done), 32'd0);
    repeat (GAP) tick();
    check("idle_ready", 32'(bus.in_ready), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_lines", 32'(bus.lines_out), 32'hF);
    $display("wave complete");
  endtask

  initial begin
    int low;
    exp_t e;
    logic [N*W-1:0] rv;

    // Reset
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) tick();
    check("rst_lines", 32'(bus.lines_out), 32'hF);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_start", 32'(bus.wave_start), 32'd0);
    check("rst_done", 32'(bus.wave_done), 32'd0);
    rst = 1'b0;
    #2;
    check("ready_before_edge", 32'(bus.in_ready), 32'd0);
    tick();
    check("ready_after_edge", 32'(bus.in_ready), 32'd1);
    $display("reset released");

    // Basic wave 12'hF43
    accept(12'hF43);
    run_cycles(T);
    finish_wave();

    // Back-to-back: in_valid stays high with A and then B
    bus.in_valid = 1'b1;
    bus.in_data  = 12'h1A6;
    push_wave(12'h1A6);
    tick();
    bus.in_data = 12'h35C;
    low = 0;
    while (bus.in_ready !== 1'b1 && low < 100) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("b2b_lines_c%0d", low), 32'(bus.lines_out), 32'(e.lines));
      end else begin
        check("b2b_gap_lines", 32'(bus.lines_out), 32'hF);
      end
      low++;
      tick();
    end
    check("b2b_ready_low_cycles", 32'(low), 32'(T + GAP));
    $display("back-to-back: in_ready low for %0d cycles", low);
    push_wave(12'h35C);
    tick();
    bus.in_valid = 1'b0;
    run_cycles(T);
    finish_wave();

    // Reset in the middle of a wave, at t = 4
    accept(12'hF43);
    run_cycles(4);
    e = exp_q.pop_front();
    check("t4_lines", 32'(bus.lines_out), 32'(e.lines));
    #2 rst = 1'b1;
    #1;
    check("midrst_lines", 32'(bus.lines_out), 32'hF);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.wave_done), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    repeat (2) begin
      tick();
      check("midrst_hold_done", 32'(bus.wave_done), 32'd0);
      check("midrst_hold_lines", 32'(bus.lines_out), 32'hF);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("midrst_ready_after", 32'(bus.in_ready), 32'd1);
    check("midrst_no_rewave", 32'(bus.lines_out), 32'hF);
    $display("mid-wave reset done");

    // Equal values: all lines fall together at t = 2
    accept(12'h492);
    run_cycles(T);
    finish_wave();

    // A few random vectors
    for (int k = 0; k < 3; k++) begin
      rv = (N*W)'($urandom);
      accept(rv);
      run_cycles(T);
      finish_wave();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/temporal_encoder.md
Name: temporal_encoder

Overview:
- Converts N binary time values into a temporal-coded wave on N lines. Each value is encoded as a 1->0 transition on its line, at a cycle offset equal to the value.
- Sits upstream of the temporal-coded sorting network and drives its raw inputs. It is the transmitter for the arrival-time protocol the sorter consumes.
- Accepts one vector of values per wave over a valid/ready handshake.
- After each wave, all lines return high for a recovery gap before the next vector can be accepted.

Parameters:
- N, 4, number of lines / values per wave.
- W, 3, bit width of each time value.
- GAP, 1, recovery cycles with all lines high after each wave; 0 is legal.

Ports:
- clk  input  1  single clock; all state is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a vector to encode.
- in_ready  output  1  encoder can accept a vector this cycle.
- in_data  input  N*W  packed values; value i is in_data[i*W +: W].
- lines_out  output  N  temporal-coded lines; idle high, line i falls at time v_i.
- wave_start  output  1  one-cycle pulse in the first RUN cycle.
- wave_done  output  1  one-cycle pulse in the last RUN cycle.
- busy  output  1  high in RUN and RECOVER.

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - State = IDLE.
  - lines_out = all ones.
  - in_ready, wave_start, wave_done, busy = 0.
  - Time counter t = 0; value registers cleared.
- in_ready is registered. It rises on the first clk edge after rst deasserts, and is high only in IDLE.
- States: IDLE, RUN, RECOVER.
- IDLE:
  - lines_out all ones.
  - Accept on the edge where in_valid && in_ready.
  - On accept: latch in_data, go to RUN with t = 0, in_ready goes 0.
  - in_data is don't-care when not accepted.
- RUN, window length T = 2^W cycles (t = 0..T-1):
  - During cycle t: lines_out[i] = 0 iff v_i <= t.
  - Consequences: value 0 is low in the first RUN cycle; a fallen line stays low to the end of the window; equal values fall in the same cycle.
  - t increments by 1 per cycle and never wraps inside a wave.
  - wave_start = 1 in the cycle t = 0.
  - wave_done = 1 in the cycle t = T-1.
- After t = T-1:
  - GAP > 0: go to RECOVER. lines_out all ones, in_ready 0, busy 1 for GAP cycles, then IDLE with in_ready = 1.
  - GAP = 0: go straight to IDLE. lines_out all ones, in_ready = 1.
- Throughput: minimum accept-to-accept spacing is T + GAP + 1 cycles, since the handshake only completes in IDLE.
- in_valid held high outside IDLE is ignored, with no side effects. Input data is never buffered.
- Reset mid-wave:
  - lines_out go high immediately.
  - No wave_done is issued.
  - The latched vector is discarded and is not re-emitted.
- Outputs are registered (no combinational path from in_* to lines_out).

Optional Feature:
- Macro: TENC_NULL_EN.
- Defined:
  - The all-ones code (2^W-1) means "no spike"; that line stays high for the whole wave.
  - Window length T = 2^W-1, i.e. t = 0..2^W-2; wave_done occurs at t = 2^W-2.
  - Spacing becomes T + GAP + 1 with the shorter T.
- Undefined:
  - All codes are valid times.
  - T = 2^W; code 2^W-1 falls in the last RUN cycle.

Test Plan (N=4, W=3, GAP=1, macro undefined unless stated):
- Reset: hold rst, then release -> lines_out = 4'b1111, in_ready = 0, busy = 0 during reset; in_ready = 1 one edge after release.
- Encode in_data = 12'hF43 (v0=3, v1=0, v2=5, v3=7):
  - RUN lines_out by t: t0 = 1101, t3 = 1100, t5 = 1000, t7 = 0000.
  - wave_start at t0; wave_done at t7.
  - Next cycle lines_out = 1111 and busy = 1; one cycle later in_ready = 1.
- Same vector with TENC_NULL_EN:
  - Line 3 never falls.
  - Last RUN cycle is t6 with lines_out = 1000 and wave_done = 1.
- Back-to-back: in_valid held high with two vectors -> in_ready low for exactly 9 cycles (8 RUN + 1 RECOVER); second accept 10 cycles after the first.
- Reset at t4 of the 12'hF43 wave -> lines_out = 1111 asynchronously; no wave_done; busy = 0; after release the next accept starts a fresh wave at t0.
- All values equal to 2 (12'h492) -> lines_out = 1111 at t0 and t1, then 0000 from t2 through t7.
